alu_ctrl_fsm: RTL and testbench

ALU_CTRL_FSM -- requirements
Module: alu_ctrl_fsm

---
 rtl/alu_ctrl_fsm.sv | 136 +++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// Byte-serial ALU controller: accepts operand A (with opcode) then operand B,
// computes add/sub/mul in one cycle and holds the result until downstream takes it.
module alu_ctrl_fsm #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_flag,
  output logic              out_zero,
  output logic              out_err,
  output logic [7:0]        op_count,
  output logic [1:0]        fsm_state
);

  // Handshakes: a byte moves when in_valid & in_ready are both high at a rising
  // edge; a result moves when out_valid & out_ready are both high at a rising edge.

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_EXEC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t state, state_next;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [1:0]          op_reg;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   calc_result;
  logic                calc_flag;
  logic                calc_err;
  logic                in_fire;
  logic                out_fire;

  assign in_ready  = (state == S_A) || (state == S_B);
  assign out_valid = (state == S_OUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign fsm_state = state;

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};

  always_comb begin
    calc_result = '0;
    calc_flag   = 1'b0;
    calc_err    = 1'b0;
    case (op_reg)
      OP_ADD: begin
        calc_result = sum[DATA_W-1:0];
        calc_flag   = sum[DATA_W];
      end
      OP_SUB: begin
        calc_result = op_a - op_b;
        calc_flag   = (op_a < op_b);
      end
      OP_MUL: begin
        calc_result = prod[DATA_W-1:0];
        calc_flag   = |prod[2*DATA_W-1:DATA_W];
      end
      default: calc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_A:     if (in_fire) state_next = S_B;
      S_B:     if (in_fire) state_next = S_EXEC;
      S_EXEC:  state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_A;
      default: state_next = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_reg <= '0;
    end else if (in_fire) begin
      if (state == S_A) begin
        op_a   <= in_data;
        op_reg <= in_op;
      end else begin
        op_b   <= in_data;
      end
    end
  end

  // Result registers only change in S_EXEC so they stay visible after consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result <= '0;
      out_flag   <= 1'b0;
      out_zero   <= 1'b1;
      out_err    <= 1'b0;
    end else if (state == S_EXEC) begin
      out_result <= calc_result;
      out_flag   <= calc_flag;
      out_zero   <= (calc_result == '0);
      out_err    <= calc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboard bench for alu_ctrl_fsm: drivers push expected results from an
// arithmetic reference model, a negedge monitor checks every presented result.
module tb_alu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_op = '0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       out_flag;
  logic       out_zero;
  logic       out_err;
  logic [7:0] op_count;
  logic [1:0] fsm_state;

  alu_ctrl_fsm #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_op      (in_op),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flag   (out_flag),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .op_count   (op_count),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];   // {err, zero, flag, result}
  int vectors = 0;
  int miscompares = 0;
  int last_b_cyc = 0;
  logic [7:0] exp_cnt = '0;
  logic after_hs = 1'b0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode meaning.
  function automatic logic [10:0] model(input int a, input int b, input int op);
    int res;
    int flag;
    int err;
    res = 0; flag = 0; err = 0;
    case (op)
      0: begin res = (a + b) % 256; flag = (a + b > 255) ? 1 : 0; end
      1: begin res = (a - b + 256) % 256; flag = (a < b) ? 1 : 0; end
      2: begin res = (a * b) % 256; flag = (a * b > 255) ? 1 : 0; end
      default: err = 1;
    endcase
    return {err[0], (res == 0), flag[0], res[7:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
      after_hs = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (after_hs) begin
        check("s_a_after_handshake", {in_ready, out_valid}, 2'b10);
      end
      after_hs = 1'b0;
      if (out_valid) begin
        check("in_ready_low_in_out", in_ready, 1'b0);
        if (!prev_valid) check("latency_b_to_valid", cyc - last_b_cyc, 2);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("result_err_zero_flag", {out_err, out_zero, out_flag, out_result}, exp_q[0]);
        end
        if (out_ready) begin
          check("op_count", op_count, exp_cnt);
          exp_cnt = exp_cnt + 8'd1;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          after_hs = 1'b1;
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- random out_ready ----------------
  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic [1:0] op, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = 0;
    in_valid = 1'b1;
    in_data = d;
    in_op = op;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom_range(0, 255));
    in_op = 2'($urandom_range(0, 3));
  endtask

  task automatic do_op(input int a, input int b, input int op);
    int c;
    send_byte(8'(a), 2'(op), c);
    send_byte(8'(b), 2'($urandom_range(0, 3)), c);
    last_b_cyc = c;
    exp_q.push_back(model(a, b, op));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_handshake", {in_ready, out_valid}, 2'b10);
    check("reset_outputs", {out_err, out_zero, out_flag, out_result}, 11'b010_0000_0000);
    check("reset_op_count", op_count, 8'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // directed arithmetic cases
    out_ready = 1'b1;
    do_op(200, 100, 0);
    do_op(5, 7, 1);
    do_op(9, 9, 1);
    do_op(16, 17, 2);
    do_op(15, 17, 2);
    drain();

    // backpressure with upstream pushing junk
    out_ready = 1'b0;
    do_op(123, 45, 2);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1; break; end
    end
    check("out_valid_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = 8'hA5;
    in_op = 2'b01;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_hold_valid", {out_valid, in_ready}, 2'b10);
      check("bp_op_count", op_count, exp_cnt);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // reserved opcode
    do_op(77, 33, 3);
    drain();

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
    end
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // 256 more results so op_count wraps
    for (int i = 0; i < 256; i++) begin
      do_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2));
    end
    drain();
    check("op_count_after_wrap", op_count, 8'((5 + 1 + 1 + 40 + 256) % 256));

    // reset while in S_B: following bytes start a fresh operation
    send_byte(8'd3, 2'b00, c);
    do_reset();
    do_op(10, 4, 1);
    drain();
    check("op_count_after_midop_reset", op_count, 8'd1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
